// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM encoding, default widths, div-by-zero quotient.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package div_pkg;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Quotient reported when the divisor is zero (all ones).
  localparam logic [DEF_DIVIDEND_W-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/restoring_divider_8by4_if.sv
// Operand/result handshake bundle for the restoring divider.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on operands, out_valid/out_ready on results.
// Ports: master = operand producer / result consumer, slave = the divider.
interface restoring_divider_8by4_if
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/sub_stage5.sv
// Ripple subtractor a - b built from full-adder cells as a + ~b + 1.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; diff = a - b (mod 2^W); no_borrow = 1 when a >= b.
module sub_stage5 #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic b_inv;
    assign b_inv        = ~b[i];
    assign diff[i]      = a[i] ^ b_inv ^ carry[i];
    assign carry[i + 1] = (a[i] & b_inv) | (a[i] & carry[i]) | (b_inv & carry[i]);
  end

  // Carry out of a + ~b + 1 is set exactly when no borrow occurred.
  assign no_borrow = carry[W];

endmodule

// File: rtl/restoring_divider_8by4.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Latency: 8 edges accept->out_valid (1 cycle for a zero divisor); one division per 10 cycles max.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst (sync, active high), bus = slave side of restoring_divider_8by4_if.
module restoring_divider_8by4
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  restoring_divider_8by4_if.slave        bus
);

  localparam int PR_W  = DIVISOR_W + 1;
  localparam int CNT_W = $clog2(DIVIDEND_W);

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [PR_W-1:0]       pr_q, pr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] qwork_q, qwork_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [PR_W-1:0]       trial;
  logic [PR_W-1:0]       diff;
  logic                  no_borrow;

  // Shift the partial remainder left and bring down the current dividend bit.
  // pr stays below the divisor, so its top bit is always zero and drops out.
  assign trial = PR_W'({pr_q, dvd_q[cnt_q]});

  sub_stage5 #(.W(PR_W)) u_sub (
    .a         (trial),
    .b         ({1'b0, dvs_q}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    qwork_d = qwork_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d = bus.dividend;
          dvs_d = bus.divisor;
          if (bus.divisor == '0) begin
            quot_d  = DIV0_QUOT;
            rem_d   = bus.dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            pr_d    = '0;
            qwork_d = '0;
            dbz_d   = 1'b0;
            cnt_d   = CNT_W'(DIVIDEND_W - 1);
            state_d = CALC;
          end
        end
      end

      CALC: begin
        pr_d           = no_borrow ? diff : trial;
        qwork_d[cnt_q] = no_borrow;
        if (cnt_q == '0) begin
          // Publish the finished result only now, so the visible outputs keep
          // the previous answer while the division is in progress.
          quot_d  = qwork_d;
          rem_d   = pr_d[DIVISOR_W-1:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      qwork_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      qwork_q <= qwork_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_8by4.sv
// Directed and exhaustive bench for restoring_divider_8by4.
// Latency: checks 8-edge normal and same-cycle-after-accept div-by-zero timing.
// Backpressure: holds out_ready low in DONE and randomises it across the sweep.
module tb_restoring_divider_8by4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  restoring_divider_8by4_if dif ();

  restoring_divider_8by4 dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, present operands for one accept edge.
  task automatic start_div(input logic [7:0] a, input logic [3:0] b);
    int n;
    n = 0;
    while (!dif.in_ready && n < 30) begin
      tick();
      n++;
    end
    if (!dif.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    dif.dividend = a;
    dif.divisor  = b;
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
  endtask

  // Number of edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!dif.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    if (!dif.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [7:0] q, input logic [3:0] r,
                              input logic z);
    chk({tag, "_quot"}, 32'(dif.quotient), 32'(q));
    chk({tag, "_rem"}, 32'(dif.remainder), 32'(r));
    chk({tag, "_dbz"}, 32'(dif.div_by_zero), 32'(z));
  endtask

  task automatic release_result(input string tag);
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
    chk({tag, "_in_ready_after_hs"}, 32'(dif.in_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(dif.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(dif.out_valid), 32'd0);
    check_result(tag, 8'd0, 4'd0, 1'b0);
  endtask

  initial begin
    int  lat;
    int  n;
    logic hs;

    rst           = 1'b1;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");

    // 200 / 13 = 15 r 5, with 8-edge latency and in_ready low during CALC
    start_div(8'd200, 4'd13);
    chk("calc_in_ready", 32'(dif.in_ready), 32'd0);
    wait_valid(lat);
    chk("lat_200_13", 32'(lat), 32'd8);
    check_result("d200_13", 8'd15, 4'd5, 1'b0);
    release_result("d200_13");

    // 255 / 1 = 255 r 0
    start_div(8'd255, 4'd1);
    wait_valid(lat);
    check_result("d255_1", 8'd255, 4'd0, 1'b0);
    release_result("d255_1");

    // 7 / 15 = 0 r 7 with out_ready held high beforehand
    dif.out_ready = 1'b1;
    start_div(8'd7, 4'd15);
    wait_valid(lat);
    chk("lat_7_15_early_rdy", 32'(lat), 32'd8);
    check_result("d7_15", 8'd0, 4'd7, 1'b0);
    tick();
    dif.out_ready = 1'b0;
    chk("d7_15_in_ready_after_hs", 32'(dif.in_ready), 32'd1);
    chk("d7_15_out_valid_after_hs", 32'(dif.out_valid), 32'd0);

    // 0 / 9 = 0 r 0, still a full 8 CALC cycles
    start_div(8'd0, 4'd9);
    wait_valid(lat);
    chk("lat_0_9", 32'(lat), 32'd8);
    check_result("d0_9", 8'd0, 4'd0, 1'b0);
    release_result("d0_9");

    // 0xA6 / 0 -> 0xFF r 6, div_by_zero, valid the cycle after accept
    start_div(8'hA6, 4'd0);
    wait_valid(lat);
    chk("lat_div0", 32'(lat), 32'd0);
    check_result("dA6_0", 8'hFF, 4'd6, 1'b1);
    release_result("dA6_0");

    // Next normal division clears div_by_zero; then hold it in DONE
    start_div(8'd200, 4'd13);
    wait_valid(lat);
    check_result("after_div0", 8'd15, 4'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      dif.dividend = 8'(i * 7 + 3);
      dif.divisor  = 4'd2;
      dif.in_valid = 1'b1;
      tick();
      chk("bp_out_valid", 32'(dif.out_valid), 32'd1);
      chk("bp_in_ready", 32'(dif.in_ready), 32'd0);
      chk("bp_quot_stable", 32'(dif.quotient), 32'd15);
      chk("bp_rem_stable", 32'(dif.remainder), 32'd5);
    end
    dif.in_valid = 1'b0;
    release_result("bp");
    chk("bp_out_valid_after_hs", 32'(dif.out_valid), 32'd0);
    tick();
    tick();
    chk("bp_no_ghost_accept", 32'(dif.out_valid), 32'd0);
    chk("bp_idle_in_ready", 32'(dif.in_ready), 32'd1);

    // Reset during the 4th CALC cycle of 170 / 3
    start_div(8'd170, 4'd3);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("mid_calc_rst");

    // 170 / 3 = 56 r 2
    start_div(8'd170, 4'd3);
    wait_valid(lat);
    chk("lat_170_3", 32'(lat), 32'd8);
    check_result("d170_3", 8'd56, 4'd2, 1'b0);
    release_result("d170_3");

    // Every non-zero-divisor pair, back to back, random out_ready
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        dif.out_ready = 1'($urandom_range(0, 1));
        start_div(8'(a), 4'(b));
        wait_valid(lat);
        chk("exh_quot", 32'(dif.quotient), 32'(a / b));
        chk("exh_rem", 32'(dif.remainder), 32'(a % b));
        chk("exh_recon", 32'(dif.quotient) * 32'(b) + 32'(dif.remainder), 32'(a));
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 50) begin
          dif.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          hs = dif.out_ready;
          #1;
          n++;
        end
        if (!hs) chk("exh_hs_timeout", 32'd0, 32'd1);
        dif.out_ready = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
